// File: rtl/fetch_redirect_unit.sv
// ---------------------------------------------------------------------------
// fetch_redirect_unit
//
// Fetch-stage PC register plus the IF/ID pipeline register of a classic
// five-stage pipeline. Branches and jumps are resolved in decode. They
// redirect fetch with a single cycle of latency, and the one wrong-path
// instruction fetched meanwhile is squashed to a bubble.
//
// Ports
//   clk            : sole clock, rising-edge
//   rst_n          : asynchronous assert, active-low reset
//   stall_f        : hold the fetch PC (decode drains to a bubble)
//   stall_d        : hold the IF/ID register (and the fetch PC)
//   pc_src_d       : branch taken, from the decode-stage comparison
//   jump_d         : J/JAL decoded in decode
//   branch_imm_d   : sign-extended branch offset, in words
//   instr_f        : instruction word at pc_f (combinational memory read)
//   pc_f           : current fetch PC
//   instr_d        : IF/ID instruction
//   pc_plus4_d     : IF/ID PC+4
//   valid_d        : IF/ID holds a real instruction (0 = bubble)
//   redirect_count : saturating count of accepted redirects
// ---------------------------------------------------------------------------
module fetch_redirect_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall_f,
    input  logic        stall_d,
    input  logic        pc_src_d,
    input  logic        jump_d,
    input  logic [31:0] branch_imm_d,
    input  logic [31:0] instr_f,
    output logic [31:0] pc_f,
    output logic [31:0] instr_d,
    output logic [31:0] pc_plus4_d,
    output logic        valid_d,
    output logic [15:0] redirect_count
);

    logic [31:0] pc_q, pc_d;
    logic [31:0] instr_d_q, instr_d_d;
    logic [31:0] pc_plus4_d_q, pc_plus4_d_d;
    logic        valid_d_q, valid_d_d;
    logic [15:0] redirect_count_q, redirect_count_d;

    logic        redirect_ok;
    logic        take_jump;
    logic        take_branch;
    logic        take_redirect;
    logic [31:0] pc_plus4_f;
    logic [31:0] branch_target;
    logic [31:0] jump_target;
    logic [31:0] next_pc;

    // A bubble in decode, or a decode stage that is frozen, cannot steer fetch.
    assign redirect_ok   = valid_d_q & ~stall_d;
    // A jump wins over a simultaneous branch and is counted once.
    assign take_jump     = jump_d & redirect_ok;
    assign take_branch   = pc_src_d & redirect_ok & ~jump_d;
    assign take_redirect = take_jump | take_branch;

    assign pc_plus4_f    = pc_q + 32'd4;
    // Word offset scaled to bytes; carry out of bit 31 is simply dropped.
    assign branch_target = pc_plus4_d_q + {branch_imm_d[29:0], 2'b00};
    assign jump_target   = {pc_plus4_d_q[31:28], instr_d_q[25:0], 2'b00};

    always_comb begin
        next_pc = pc_plus4_f;
        if (take_jump) begin
            next_pc = jump_target;
        end else if (take_branch) begin
            next_pc = branch_target;
        end
    end

    always_comb begin
        pc_d             = pc_q;
        instr_d_d        = instr_d_q;
        pc_plus4_d_d     = pc_plus4_d_q;
        valid_d_d        = valid_d_q;
        redirect_count_d = redirect_count_q;

        if (!stall_f && !stall_d) begin
            pc_d = next_pc;
        end

        if (!stall_d) begin
            if (take_redirect || stall_f) begin
                // Squash the wrong-path fetch, or drain decode while fetch waits.
                instr_d_d    = 32'h0000_0000;
                pc_plus4_d_d = 32'h0000_0000;
                valid_d_d    = 1'b0;
            end else begin
                instr_d_d    = instr_f;
                pc_plus4_d_d = pc_plus4_f;
                valid_d_d    = 1'b1;
            end
        end

        if (take_redirect && (redirect_count_q != 16'hFFFF)) begin
            redirect_count_d = redirect_count_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q             <= RESET_PC;
            instr_d_q        <= 32'h0000_0000;
            pc_plus4_d_q     <= 32'h0000_0000;
            valid_d_q        <= 1'b0;
            redirect_count_q <= 16'h0000;
        end else begin
            pc_q             <= pc_d;
            instr_d_q        <= instr_d_d;
            pc_plus4_d_q     <= pc_plus4_d_d;
            valid_d_q        <= valid_d_d;
            redirect_count_q <= redirect_count_d;
        end
    end

    assign pc_f           = pc_q;
    assign instr_d        = instr_d_q;
    assign pc_plus4_d     = pc_plus4_d_q;
    assign valid_d        = valid_d_q;
    assign redirect_count = redirect_count_q;

endmodule

// File: doc/fetch_redirect_unit.md
FETCH_REDIRECT_UNIT -- requirements
Module: fetch_redirect_unit

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, meaning the PC value loaded on reset.
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 SHALL have port stall_f  input  1  hazard-unit request to hold the fetch PC.
REQ-005 SHALL have port stall_d  input  1  hazard-unit request to hold the IF/ID register.
REQ-006 SHALL have port pc_src_d  input  1  branch-taken decision from the decode-stage branch comparison.
REQ-007 SHALL have port jump_d  input  1  decoded J/JAL in decode.
REQ-008 SHALL have port branch_imm_d  input  32  sign-extended branch offset, in words.
REQ-009 SHALL have port instr_f  input  32  instruction word read combinationally at pc_f.
REQ-010 SHALL have port pc_f  output  32  current fetch PC (instruction-memory address).
REQ-011 SHALL have port instr_d  output  32  IF/ID instruction.
REQ-012 SHALL have port pc_plus4_d  output  32  IF/ID PC+4.
REQ-013 SHALL have port valid_d  output  1  IF/ID holds a real instruction (0 = bubble).
REQ-014 SHALL have port redirect_count  output  16  saturating count of accepted redirects.

Function
REQ-015 SHALL compute pc_plus4_f = pc_f + 4 modulo 2^32 (0xFFFF_FFFC wraps to 0x0000_0000).
REQ-016 SHALL compute branch target = pc_plus4_d + (branch_imm_d << 2) modulo 2^32; overflow discarded.
REQ-017 SHALL compute jump target = {pc_plus4_d[31:28], instr_d[25:0], 2'b00}.
REQ-018 SHALL define redirect_ok = valid_d & ~stall_d; pc_src_d/jump_d SHALL be ignored when redirect_ok = 0.
REQ-019 SHALL select next PC by priority: jump_d & redirect_ok -> jump target; else pc_src_d & redirect_ok -> branch target; else pc_plus4_f.
REQ-020 SHALL hold pc_f when stall_f = 1 or stall_d = 1; otherwise load next PC each cycle.
REQ-021 SHALL hold instr_d, pc_plus4_d, valid_d unchanged when stall_d = 1 (stall dominates all else).
REQ-022 SHALL, when stall_d = 0 and a redirect is taken (REQ-019 first two cases), load the IF/ID register with a bubble next edge: instr_d = 0, pc_plus4_d = 0, valid_d = 0 (no delay slot).
REQ-023 SHALL, when stall_d = 0, no redirect, stall_f = 0, load instr_d = instr_f, pc_plus4_d = pc_plus4_f, valid_d = 1.
REQ-024 SHALL, when stall_d = 0, no redirect, stall_f = 1, load a bubble into IF/ID (fetch held, decode drains).
REQ-025 SHALL be a single-cycle redirect: target appears on pc_f the edge after the decision; exactly one wrong-path fetch is squashed.
REQ-026 SHALL increment redirect_count by 1 on each edge where a redirect is taken, saturating at 16'hFFFF.
REQ-027 SHALL treat simultaneous jump_d and pc_src_d as a jump, counted once.
REQ-028 SHALL produce pc_f, instr_d, pc_plus4_d, valid_d, redirect_count directly from registers (no input-to-output combinational path).

Reset
REQ-029 SHALL, on rst_n = 0 at any time including mid-stall or mid-redirect, immediately set pc_f = RESET_PC, instr_d = 0, pc_plus4_d = 0, valid_d = 0, redirect_count = 0.
REQ-030 SHALL, on first edge after rst_n deasserts with no stalls, load IF/ID with instr_f at RESET_PC, valid_d = 1, and pc_f = RESET_PC + 4.

Verification
REQ-031 SHALL cover sequential fetch: reset, no stalls, 4 edges -> pc_f = 0x10, pc_plus4_d = 0x10, valid_d = 1.
REQ-032 SHALL cover taken branch: pc_plus4_d = 0x24, branch_imm_d = 0xFFFF_FFFC, pc_src_d = 1 -> next pc_f = 0x14, valid_d = 0, redirect_count +1.
REQ-033 SHALL cover jump priority: instr_d = 0x0800_0040, pc_plus4_d = 0x0000_0008, jump_d = 1, pc_src_d = 1 -> next pc_f = 0x0000_0100, redirect_count +1 only.
REQ-034 SHALL cover stalled branch: stall_f = stall_d = 1, pc_src_d = 1 for 3 cycles -> pc_f, IF/ID, redirect_count unchanged; redirect taken on the cycle stall releases.
REQ-035 SHALL cover wrap and saturation: pc_f = 0xFFFF_FFFC -> next 0x0; redirect_count = 0xFFFF plus redirect -> stays 0xFFFF.
REQ-036 SHALL cover async reset mid-redirect: rst_n low between edges while pc_src_d = 1 -> outputs at reset values before the next edge.
